// File: rtl/decode_pkg.sv
// Shared decode types and instruction-class predicates for the decode queue.
// The instruction/PC width comes from `W_DATA, which defaults to 32 when not set.
`ifndef W_DATA
`define W_DATA 32
`endif

package decode_pkg;

    localparam int W = `W_DATA;

    typedef enum logic [3:0] {
        IT_ALU,
        IT_JUMP,
        IT_BRANCH,
        IT_LOAD,
        IT_STORE,
        IT_MFC0,
        IT_MTC0,
        IT_ERET,
        IT_SYS,
        IT_RSV
    } ityp_e;

    // rs/rt are the raw instruction fields; rd is the GPR actually written (0 = none)
    typedef struct packed {
        logic [W-1:0] pc;
        ityp_e        ityp;
        logic [5:0]   oper;
        logic [5:0]   func;
        logic [W-1:0] imme;
        logic [4:0]   rs;
        logic [4:0]   rt;
        logic [4:0]   rd;
        logic         sy;
        logic         bp;
        logic         ri;
        logic         er;
    } dec_t;

    function automatic logic is_jb(input dec_t d);
        return (d.ityp == IT_JUMP) || (d.ityp == IT_BRANCH);
    endfunction

    function automatic logic is_mem(input dec_t d);
        return (d.ityp == IT_LOAD) || (d.ityp == IT_STORE);
    endfunction

    // Instructions that must issue without a partner in slot 1
    function automatic logic is_solo(input dec_t d);
        return d.sy || d.bp || d.er || d.ri || (d.ityp == IT_MFC0) || (d.ityp == IT_MTC0);
    endfunction

endpackage

// File: rtl/decode_slot.sv
// Single-slot combinational MIPS-I decoder: raw instruction word + PC -> dec_t.
module decode_slot
    import decode_pkg::*;
(
    input  logic [W-1:0] inst,
    input  logic [W-1:0] pc,
    output dec_t         dec
);

    logic [5:0]  op;
    logic [5:0]  fn;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd_f;
    logic [4:0]  sa;
    logic [15:0] imm;

    assign op   = inst[31:26];
    assign rs   = inst[25:21];
    assign rt   = inst[20:16];
    assign rd_f = inst[15:11];
    assign sa   = inst[10:6];
    assign fn   = inst[5:0];
    assign imm  = inst[15:0];

    always_comb begin
        dec      = '0;
        dec.pc   = pc;
        dec.oper = op;
        dec.func = fn;
        dec.rs   = rs;
        dec.rt   = rt;
        dec.ityp = IT_ALU;
        case (op)
            6'h00: begin
                dec.imme = {{(W-5){1'b0}}, sa};
                dec.rd   = rd_f;
                case (fn)
                    6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h10, 6'h12,
                    6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                    6'h2a, 6'h2b: dec.rd = rd_f;
                    6'h08: begin
                        dec.ityp = IT_JUMP;
                        dec.rd   = '0;
                    end
                    6'h09: begin
                        dec.ityp = IT_JUMP;
                        dec.rd   = (rd_f == 5'd0) ? 5'd31 : rd_f;
                    end
                    6'h0c: begin
                        dec.ityp = IT_SYS;
                        dec.sy   = 1'b1;
                        dec.rd   = '0;
                    end
                    6'h0d: begin
                        dec.ityp = IT_SYS;
                        dec.bp   = 1'b1;
                        dec.rd   = '0;
                    end
                    6'h11, 6'h13, 6'h18, 6'h19, 6'h1a, 6'h1b: dec.rd = '0;
                    default: begin
                        dec.ityp = IT_RSV;
                        dec.ri   = 1'b1;
                        dec.rd   = '0;
                    end
                endcase
            end
            6'h01: begin
                dec.imme = {{(W-16){imm[15]}}, imm};
                dec.ityp = IT_BRANCH;
                case (rt)
                    5'h00, 5'h01: dec.rd = '0;
                    5'h10, 5'h11: dec.rd = 5'd31;
                    default: begin
                        dec.ityp = IT_RSV;
                        dec.ri   = 1'b1;
                    end
                endcase
            end
            6'h02, 6'h03: begin
                dec.ityp = IT_JUMP;
                dec.imme = {{(W-26){1'b0}}, inst[25:0]};
                dec.rd   = (op == 6'h03) ? 5'd31 : 5'd0;
            end
            6'h04, 6'h05, 6'h06, 6'h07: begin
                dec.ityp = IT_BRANCH;
                dec.imme = {{(W-16){imm[15]}}, imm};
            end
            6'h08, 6'h09, 6'h0a, 6'h0b: begin
                dec.imme = {{(W-16){imm[15]}}, imm};
                dec.rd   = rt;
            end
            6'h0c, 6'h0d, 6'h0e: begin
                dec.imme = {{(W-16){1'b0}}, imm};
                dec.rd   = rt;
            end
            6'h0f: begin
                dec.imme = {imm, {(W-16){1'b0}}};
                dec.rd   = rt;
            end
            6'h10: begin
                if (rs == 5'h00) begin
                    dec.ityp = IT_MFC0;
                    dec.rd   = rt;
                end else if (rs == 5'h04) begin
                    dec.ityp = IT_MTC0;
                end else if (rs == 5'h10 && fn == 6'h18) begin
                    dec.ityp = IT_ERET;
                    dec.er   = 1'b1;
                end else begin
                    dec.ityp = IT_RSV;
                    dec.ri   = 1'b1;
                end
            end
            6'h20, 6'h21, 6'h23, 6'h24, 6'h25: begin
                dec.ityp = IT_LOAD;
                dec.imme = {{(W-16){imm[15]}}, imm};
                dec.rd   = rt;
            end
            6'h28, 6'h29, 6'h2b: begin
                dec.ityp = IT_STORE;
                dec.imme = {{(W-16){imm[15]}}, imm};
            end
            default: begin
                dec.ityp = IT_RSV;
                dec.ri   = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/decode_queue.sv
// Two-wide decode queue: circular buffer of raw inst/pc with dual-slot decode and issue pairing.
// Optional same-cycle bypass of pushes into an empty queue: define DECODE_QUEUE_BYPASS_EN.
module decode_queue
    import decode_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic [1:0]          in_cnt,
    input  logic [1:0][W-1:0]   in_inst,
    input  logic [1:0][W-1:0]   in_pc,
    output logic                in_ready,
    output logic [1:0]          out_cnt,
    output dec_t [1:0]          out_dec,
    input  logic [1:0]          out_ack
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [W-1:0]  inst_mem_q [DEPTH];
    logic [W-1:0]  pc_mem_q   [DEPTH];

    logic [1:0]          push_cnt, avail, offer, ack_cnt, skip, pop_cnt, wr_cnt;
    logic                byp;
    logic [1:0][W-1:0]   slot_inst, slot_pc;
    dec_t [1:0]          dec;
    logic [1:0]          wr_en;
    logic [1:0][AW-1:0]  wr_addr;
    logic [1:0][W-1:0]   wr_inst, wr_pc;

    assign in_ready = (count_q <= CW'(DEPTH - 2));
    assign push_cnt = (in_ready && !flush) ? ((in_cnt == 2'd3) ? 2'd2 : in_cnt) : 2'd0;

`ifdef DECODE_QUEUE_BYPASS_EN
    assign byp = (count_q == '0) && !flush && !rst && (push_cnt != 2'd0);
`else
    assign byp = 1'b0;
`endif

    always_comb begin
        if (byp) begin
            slot_inst = in_inst;
            slot_pc   = in_pc;
            avail     = push_cnt;
        end else begin
            slot_inst[0] = inst_mem_q[head_q];
            slot_inst[1] = inst_mem_q[head_q + AW'(1)];
            slot_pc[0]   = pc_mem_q[head_q];
            slot_pc[1]   = pc_mem_q[head_q + AW'(1)];
            avail        = (count_q >= CW'(2)) ? 2'd2 : count_q[1:0];
        end
    end

    decode_slot u_slot0 (.inst(slot_inst[0]), .pc(slot_pc[0]), .dec(dec[0]));
    decode_slot u_slot1 (.inst(slot_inst[1]), .pc(slot_pc[1]), .dec(dec[1]));

    // A lone jump/branch waits for its delay slot; the RAW check is skipped behind a branch
    always_comb begin
        offer = 2'd0;
        if (rst || flush || avail == 2'd0) begin
            offer = 2'd0;
        end else if (avail == 2'd1) begin
            offer = is_jb(dec[0]) ? 2'd0 : 2'd1;
        end else if (is_solo(dec[0]) || is_jb(dec[1]) || (is_mem(dec[0]) && is_mem(dec[1]))) begin
            offer = 2'd1;
        end else if (!is_jb(dec[0]) && dec[0].rd != 5'd0 &&
                     (dec[0].rd == dec[1].rs || dec[0].rd == dec[1].rt)) begin
            offer = 2'd1;
        end else begin
            offer = 2'd2;
        end
    end

    assign out_cnt    = offer;
    assign out_dec[0] = (offer != 2'd0) ? dec[0] : '0;
    assign out_dec[1] = (offer == 2'd2) ? dec[1] : '0;

    // Acked bypassed instructions never enter the buffer; the rest are written in order
    assign ack_cnt = (out_ack > offer) ? offer : out_ack;
    assign skip    = byp ? ack_cnt : 2'd0;
    assign pop_cnt = byp ? 2'd0 : ack_cnt;
    assign wr_cnt  = push_cnt - skip;

    always_comb begin
        wr_en[0]   = !flush && (wr_cnt != 2'd0);
        wr_en[1]   = !flush && (wr_cnt == 2'd2);
        wr_addr[0] = tail_q;
        wr_addr[1] = tail_q + AW'(1);
        wr_inst[0] = in_inst[skip[0]];
        wr_inst[1] = in_inst[1];
        wr_pc[0]   = in_pc[skip[0]];
        wr_pc[1]   = in_pc[1];
    end

    always_comb begin
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            head_d  = head_q + AW'(pop_cnt);
            tail_d  = tail_q + AW'(wr_cnt);
            count_d = count_q + CW'(wr_cnt) - CW'(pop_cnt);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (wr_en[i]) begin
                inst_mem_q[wr_addr[i]] <= wr_inst[i];
                pc_mem_q[wr_addr[i]]   <= wr_pc[i];
            end
        end
    end

endmodule

// File: tb/tb_decode_queue.sv
// Self-checking bench for decode_queue: decode table, directed corner sequences, random vs queue model.
`ifndef W_DATA
`define W_DATA 32
`endif

module tb_decode_queue;
    import decode_pkg::*;

    localparam int DEPTH = 8;
`ifdef DECODE_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    localparam logic [31:0] NOP = 32'h0000_0000;

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      flush;
    logic [1:0]                in_cnt;
    logic [1:0][`W_DATA-1:0]   in_inst;
    logic [1:0][`W_DATA-1:0]   in_pc;
    logic                      in_ready;
    logic [1:0]                out_cnt;
    dec_t [1:0]                out_dec;
    logic [1:0]                out_ack;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    decode_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_cnt(in_cnt), .in_inst(in_inst),
        .in_pc(in_pc), .in_ready(in_ready), .out_cnt(out_cnt), .out_dec(out_dec),
        .out_ack(out_ack)
    );

    typedef struct {
        logic [31:0] inst;
        ityp_e       ityp;
        logic [4:0]  rd;
        logic [31:0] imme;
        logic [3:0]  flags;   // {sy, bp, ri, er}
        logic [1:0]  cnt;     // out_cnt with a nop behind it
    } vec_t;

    typedef struct {
        logic [31:0] w;
        logic [31:0] pc;
        bit          jb;
        bit          mem;
        bit          solo;
        logic [4:0]  rd;
    } rec_t;

    vec_t tbl[20];
    rec_t q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] n, input logic [31:0] i0, input logic [31:0] p0,
                         input logic [31:0] i1, input logic [31:0] p1,
                         input logic [1:0] ack, input logic fl);
        in_cnt     = n;
        in_inst[0] = i0;
        in_pc[0]   = p0;
        in_inst[1] = i1;
        in_pc[1]   = p1;
        out_ack    = ack;
        flush      = fl;
        #1;
    endtask

    task automatic idle();
        drive(2'd0, NOP, 32'h0, NOP, 32'h0, 2'd0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Random instruction with its class known from how it was built
    function automatic rec_t gen(input logic [31:0] pc);
        rec_t r;
        int k;
        logic [4:0] a, b, c;
        logic [15:0] im;
        k  = $urandom_range(0, 9);
        a  = 5'($urandom_range(0, 7));
        b  = 5'($urandom_range(0, 7));
        c  = 5'($urandom_range(0, 7));
        im = 16'($urandom);
        r.pc = pc; r.jb = 0; r.mem = 0; r.solo = 0; r.rd = 0;
        case (k)
            0, 1, 2: begin r.w = {6'h00, a, b, c, 5'h0, 6'h21}; r.rd = c; end
            3:       begin r.w = {6'h23, a, b, im}; r.mem = 1; r.rd = b; end
            4:       begin r.w = {6'h2b, a, b, im}; r.mem = 1; end
            5:       begin r.w = {6'h04, a, b, im}; r.jb = 1; end
            6:       begin r.w = {6'h03, 26'($urandom)}; r.jb = 1; r.rd = 5'd31; end
            7:       begin r.w = 32'h0000_000C; r.solo = 1; end
            8:       begin r.w = {6'h10, 5'h00, b, 5'd12, 11'h0}; r.solo = 1; r.rd = b; end
            default: begin r.w = {6'h0d, a, b, im}; r.rd = b; end
        endcase
        return r;
    endfunction

    function automatic int exp_cnt(input rec_t s0, input rec_t s1, input int n);
        if (n == 0) return 0;
        if (n == 1) return s0.jb ? 0 : 1;
        if (s0.solo || s1.jb || (s0.mem && s1.mem)) return 1;
        if (!s0.jb && s0.rd != 0 && (s0.rd == s1.w[25:21] || s0.rd == s1.w[20:16])) return 1;
        return 2;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{32'h00221821, IT_ALU,    5'd3,  32'h0,        4'b0000, 2'd2};
        tbl[1]  = '{32'h0C000100, IT_JUMP,   5'd31, 32'h100,      4'b0000, 2'd2};
        tbl[2]  = '{32'h00800009, IT_JUMP,   5'd31, 32'h0,        4'b0000, 2'd2};
        tbl[3]  = '{32'h0451FFFF, IT_BRANCH, 5'd31, 32'hFFFFFFFF, 4'b0000, 2'd2};
        tbl[4]  = '{32'h0000000C, IT_SYS,    5'd0,  32'h0,        4'b1000, 2'd1};
        tbl[5]  = '{32'h0000000D, IT_SYS,    5'd0,  32'h0,        4'b0100, 2'd1};
        tbl[6]  = '{32'h42000018, IT_ERET,   5'd0,  32'h0,        4'b0001, 2'd1};
        tbl[7]  = '{32'hFC000000, IT_RSV,    5'd0,  32'h0,        4'b0010, 2'd1};
        tbl[8]  = '{32'h34058000, IT_ALU,    5'd5,  32'h00008000, 4'b0000, 2'd2};
        tbl[9]  = '{32'h3C071234, IT_ALU,    5'd7,  32'h12340000, 4'b0000, 2'd2};
        tbl[10] = '{32'h8FA8FFFC, IT_LOAD,   5'd8,  32'hFFFFFFFC, 4'b0000, 2'd2};
        tbl[11] = '{32'hAFA80000, IT_STORE,  5'd0,  32'h0,        4'b0000, 2'd2};
        tbl[12] = '{32'h40096000, IT_MFC0,   5'd9,  32'h0,        4'b0000, 2'd1};
        tbl[13] = '{32'h40896000, IT_MTC0,   5'd0,  32'h0,        4'b0000, 2'd1};
        tbl[14] = '{32'h000520C3, IT_ALU,    5'd4,  32'h3,        4'b0000, 2'd2};
        tbl[15] = '{32'h10220004, IT_BRANCH, 5'd0,  32'h4,        4'b0000, 2'd2};
        tbl[16] = '{32'h03E00008, IT_JUMP,   5'd0,  32'h0,        4'b0000, 2'd2};
        tbl[17] = '{32'h00000001, IT_RSV,    5'd0,  32'h0,        4'b0010, 2'd1};
        tbl[18] = '{32'h2402FFFF, IT_ALU,    5'd2,  32'hFFFFFFFF, 4'b0000, 2'd2};
        tbl[19] = '{32'h00220018, IT_ALU,    5'd0,  32'h0,        4'b0000, 2'd2};

        // Reset: pushes held off, outputs quiet
        rst = 1'b1;
        drive(2'd2, NOP, 32'h10, NOP, 32'h14, 2'd0, 1'b0);
        tick();
        tick();
        chk("rst_out_cnt", 64'(out_cnt), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_dec_zero", 64'(out_dec == '0), 64'd1);
        idle();
        rst = 1'b0;
        tick();
        chk("post_rst_empty", 64'(out_cnt), 64'd0);

        // Decode table: each instruction followed by a nop
        for (int k = 0; k < 20; k++) begin
            drive(2'd2, tbl[k].inst, 32'h1000 + 32'(k * 16), NOP, 32'h1004 + 32'(k * 16), 2'd0, 1'b0);
            tick();
            idle();
            chk($sformatf("tbl%0d_cnt", k), 64'(out_cnt), 64'(tbl[k].cnt));
            chk($sformatf("tbl%0d_ityp", k), 64'(out_dec[0].ityp), 64'(tbl[k].ityp));
            chk($sformatf("tbl%0d_rd", k), 64'(out_dec[0].rd), 64'(tbl[k].rd));
            chk($sformatf("tbl%0d_imme", k), 64'(out_dec[0].imme), 64'(tbl[k].imme));
            chk($sformatf("tbl%0d_flags", k),
                64'({out_dec[0].sy, out_dec[0].bp, out_dec[0].ri, out_dec[0].er}), 64'(tbl[k].flags));
            chk($sformatf("tbl%0d_pc", k), 64'(out_dec[0].pc), 64'(32'h1000 + 32'(k * 16)));
            drive(2'd0, NOP, 32'h0, NOP, 32'h0, 2'd0, 1'b1);
            tick();
            idle();
        end

        // RAW pair issues one at a time
        drive(2'd2, 32'h00221821, 32'h100, 32'h00642821, 32'h104, 2'd0, 1'b0);
        tick();
        idle();
        chk("raw_cnt", 64'(out_cnt), 64'd1);
        chk("raw_pc0", 64'(out_dec[0].pc), 64'h100);
        drive(2'd0, NOP, 32'h0, NOP, 32'h0, 2'd1, 1'b0);
        tick();
        idle();
        chk("raw_second_cnt", 64'(out_cnt), 64'd1);
        chk("raw_second_pc", 64'(out_dec[0].pc), 64'h104);
        chk("raw_second_rd", 64'(out_dec[0].rd), 64'd5);
        drive(2'd0, NOP, 32'h0, NOP, 32'h0, 2'd1, 1'b0);
        tick();
        idle();
        chk("raw_drained", 64'(out_cnt), 64'd0);

        // Branch waits for its delay slot
        drive(2'd1, 32'h10220004, 32'h200, NOP, 32'h0, 2'd0, 1'b0);
        tick();
        idle();
        chk("br_alone_cnt", 64'(out_cnt), 64'd0);
        drive(2'd1, NOP, 32'h204, NOP, 32'h0, 2'd0, 1'b0);
        tick();
        idle();
        chk("br_pair_cnt", 64'(out_cnt), 64'd2);
        chk("br_pair_ityp", 64'(out_dec[0].ityp), 64'(IT_BRANCH));
        chk("br_pair_pc1", 64'(out_dec[1].pc), 64'h204);
        drive(2'd0, NOP, 32'h0, NOP, 32'h0, 2'd2, 1'b0);
        tick();
        idle();

        // Fill to full, overflow push ignored, drain in order
        for (int c = 0; c < 4; c++) begin
            drive(2'd2, NOP, 32'h300 + 32'(c * 8), NOP, 32'h304 + 32'(c * 8), 2'd0, 1'b0);
            tick();
        end
        idle();
        chk("full_in_ready", 64'(in_ready), 64'd0);
        chk("full_cnt", 64'(out_cnt), 64'd2);
        drive(2'd2, NOP, 32'h400, NOP, 32'h404, 2'd0, 1'b0);
        tick();
        for (int c = 0; c < 4; c++) begin
            drive(2'd0, NOP, 32'h0, NOP, 32'h0, 2'd2, 1'b0);
            chk($sformatf("drain%0d_pc0", c), 64'(out_dec[0].pc), 64'(32'h300 + 32'(c * 8)));
            chk($sformatf("drain%0d_pc1", c), 64'(out_dec[1].pc), 64'(32'h304 + 32'(c * 8)));
            tick();
            if (c == 0) chk("after_ack_in_ready", 64'(in_ready), 64'd1);
        end
        idle();
        chk("overflow_dropped", 64'(out_cnt), 64'd0);

        // Flush beats simultaneous push and ack
        for (int c = 0; c < 3; c++) begin
            drive(2'd2, NOP, 32'h700 + 32'(c * 8), NOP, 32'h704 + 32'(c * 8), 2'd0, 1'b0);
            tick();
        end
        drive(2'd2, NOP, 32'h780, NOP, 32'h784, 2'd2, 1'b1);
        chk("flush_comb_cnt", 64'(out_cnt), 64'd0);
        tick();
        idle();
        chk("flush_next_cnt", 64'(out_cnt), 64'd0);
        chk("flush_in_ready", 64'(in_ready), 64'd1);
        tick();
        chk("flush_stays_empty", 64'(out_cnt), 64'd0);

        // Syscall issues alone
        drive(2'd2, 32'h0000000C, 32'h500, 32'h00221821, 32'h504, 2'd0, 1'b0);
        tick();
        idle();
        chk("sys_cnt", 64'(out_cnt), 64'd1);
        chk("sys_sy", 64'(out_dec[0].sy), 64'd1);
        drive(2'd0, NOP, 32'h0, NOP, 32'h0, 2'd1, 1'b0);
        tick();
        idle();
        chk("sys_next_cnt", 64'(out_cnt), 64'd1);
        chk("sys_next_pc", 64'(out_dec[0].pc), 64'h504);
        chk("sys_next_ityp", 64'(out_dec[0].ityp), 64'(IT_ALU));
        drive(2'd0, NOP, 32'h0, NOP, 32'h0, 2'd1, 1'b0);
        tick();
        idle();

`ifdef DECODE_QUEUE_BYPASS_EN
        drive(2'd2, 32'h8FA8FFFC, 32'h600, 32'hAFA80000, 32'h604, 2'd1, 1'b0);
        chk("byp_cnt", 64'(out_cnt), 64'd1);
        chk("byp_pc", 64'(out_dec[0].pc), 64'h600);
        chk("byp_ityp", 64'(out_dec[0].ityp), 64'(IT_LOAD));
        tick();
        idle();
        chk("byp_stored_cnt", 64'(out_cnt), 64'd1);
        chk("byp_stored_pc", 64'(out_dec[0].pc), 64'h604);
        drive(2'd0, NOP, 32'h0, NOP, 32'h0, 2'd1, 1'b0);
        tick();
        idle();
        chk("byp_drained", 64'(out_cnt), 64'd0);
`else
        drive(2'd2, NOP, 32'h600, NOP, 32'h604, 2'd0, 1'b0);
        chk("latency_same_cycle", 64'(out_cnt), 64'd0);
        tick();
        idle();
        chk("latency_next_cycle", 64'(out_cnt), 64'd2);
        drive(2'd0, NOP, 32'h0, NOP, 32'h0, 2'd2, 1'b0);
        tick();
        idle();
`endif

        // Reset mid-operation discards contents
        for (int c = 0; c < 2; c++) begin
            drive(2'd2, NOP, 32'h800 + 32'(c * 8), NOP, 32'h804 + 32'(c * 8), 2'd0, 1'b0);
            tick();
        end
        idle();
        rst = 1'b1;
        #1;
        chk("midrst_cnt", 64'(out_cnt), 64'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("midrst_after_cnt", 64'(out_cnt), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        drive(2'd2, NOP, 32'h900, NOP, 32'h904, 2'd0, 1'b0);
        tick();
        idle();
        chk("midrst_resume", 64'(out_cnt), 64'd2);
        drive(2'd0, NOP, 32'h0, NOP, 32'h0, 2'd0, 1'b1);
        tick();
        idle();

        // Random traffic against a queue model
        begin
            logic [31:0] pc;
            rec_t a0, a1;
            rec_t view[2];
            int n, ack, e, vn, ackc;
            bit fl, rdy, byp_now, slow;
            pc = 32'h1_0000;
            q.delete();
            for (int cyc = 0; cyc < 3000; cyc++) begin
                slow = ((cyc / 150) % 2) == 1;
                a0  = gen(pc);
                a1  = gen(pc + 4);
                n   = $urandom_range(0, 2);
                ack = slow ? $urandom_range(0, 1) : $urandom_range(0, 2);
                fl  = ($urandom_range(0, 63) == 0);
                drive(2'(n), a0.w, a0.pc, a1.w, a1.pc, 2'(ack), fl);
                rdy     = (DEPTH - q.size()) >= 2;
                byp_now = BYP && q.size() == 0 && !fl && rdy && n > 0;
                if (byp_now) begin
                    vn = n;
                    view[0] = a0;
                    view[1] = a1;
                end else begin
                    vn = (q.size() >= 2) ? 2 : q.size();
                    view[0] = (q.size() > 0) ? q[0] : a0;
                    view[1] = (q.size() > 1) ? q[1] : a1;
                end
                e = fl ? 0 : exp_cnt(view[0], view[1], vn);
                chk("rnd_out_cnt", 64'(out_cnt), 64'(e));
                chk("rnd_in_ready", 64'(in_ready), 64'(rdy));
                for (int i = 0; i < e; i++) begin
                    chk("rnd_pc", 64'(out_dec[i].pc), 64'(view[i].pc));
                    chk("rnd_rd", 64'(out_dec[i].rd), 64'(view[i].rd));
                end
                tick();
                if (fl) begin
                    q.delete();
                end else begin
                    ackc = (ack > e) ? e : ack;
                    if (byp_now) begin
                        if (ackc < 1 && n > 0) q.push_back(a0);
                        if (ackc < 2 && n > 1) q.push_back(a1);
                    end else begin
                        for (int j = 0; j < ackc; j++) void'(q.pop_front());
                        if (rdy && n > 0) q.push_back(a0);
                        if (rdy && n > 1) q.push_back(a1);
                    end
                end
                pc = pc + 8;
            end
        end

        idle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/decode_queue.md
DECODE_QUEUE -- requirements
Module: decode_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8, buffer entries; power of two, 4..64.
REQ-002 SHALL have port clk  in  1  sole clock, all state rising-edge.
REQ-003 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have port flush  in  1  discard all buffered and presented instructions.
REQ-005 SHALL have port in_cnt  in  2  instructions pushed this cycle, 0..2; slot 0 is older.
REQ-006 SHALL have port in_inst  in  2x`W_DATA  raw instruction words.
REQ-007 SHALL have port in_pc  in  2x`W_DATA  PCs of in_inst.
REQ-008 SHALL have port in_ready  out  1  high when free entries >= 2.
REQ-009 SHALL have port out_cnt  out  2  decoded instructions offered, 0..2; slot 0 is older.
REQ-010 SHALL have port out_dec  out  2xdec_t  per slot: pc, ityp, oper, func, imme, rs/rt/rd, sy, bp, ri, er.
REQ-011 SHALL have port out_ack  in  2  instructions consumed this cycle, oldest first, 0..out_cnt.

Function
REQ-012 SHALL store raw inst+pc in a circular buffer (head/tail pointers, count width clog2(DEPTH)+1) and decode head and head+1 combinationally.
REQ-013 SHALL accept a push only when in_ready=1 and flush=0; when in_ready=0, in_cnt is ignored.
REQ-014 SHALL update count <= count + accepted in_cnt - out_ack on the same edge; simultaneous push and pop are legal at any fill level.
REQ-015 SHALL clip out_ack to out_cnt; excess ack is ignored.
REQ-016 SHALL wrap pointers modulo DEPTH; full (count=DEPTH) and empty (count=0) are distinguished by count.
REQ-017 SHALL set out_cnt=0 when count=0 or flush=1.
REQ-018 SHALL set out_cnt=0 when slot 0 is a jump/branch and count=1, holding it until its delay slot arrives.
REQ-019 SHALL set out_cnt=1 when slot 0 is syscall, break, eret, reserved, mtc0 or mfc0.
REQ-020 SHALL set out_cnt=1 when slot 1 is jump/branch.
REQ-021 SHALL set out_cnt=1 when both slots are load/store.
REQ-022 SHALL set out_cnt=1 when slot 0 is not jump/branch and slot 0 rd!=0 equals slot 1 rs or rt.
REQ-023 SHALL skip the RAW check of REQ-022 when slot 0 is jump/branch, so a branch pairs with its delay slot.
REQ-024 SHALL set out_cnt=2 when count>=2 and none of REQ-017..REQ-022 applies, otherwise out_cnt=1 when count>=1.
REQ-025 SHALL, on flush, zero head, tail and count at the next edge, and ignore push and ack in that cycle.
REQ-026 SHALL decode fields exactly as the existing single-slot decoder does, including link rd=31 for jal/bltzal/bgezal and jalr rd=0 -> 31.
REQ-027 SHALL keep decoded outputs stable while out_cnt>0 and out_ack=0.

Reset
REQ-028 SHALL, while rst=1, hold head=tail=count=0, out_cnt=0, in_ready=1 and out_dec all-zero.
REQ-029 SHALL discard entries in flight on reset mid-operation; operation resumes on the first edge after deassertion.

Configuration
REQ-030 SHALL, with DECODE_QUEUE_BYPASS_EN defined, present pushed instructions on out_dec in the same cycle when count=0, flush=0 and rst=0, applying REQ-018..REQ-024 to them; acked bypassed instructions are not written, unacked ones are.
REQ-031 SHALL, without DECODE_QUEUE_BYPASS_EN, give pushed instructions a minimum latency of one cycle to out_cnt>0.

Structure
REQ-032 SHALL place dec_t (packed struct of decode fields plus pc) and the jump/branch/memory class predicates in shared package decode_pkg.
REQ-033 SHALL instantiate the combinational sub-module decode_slot (inst -> dec_t) twice, once per output slot.

Verification
REQ-034 SHALL cover: push addu $3,$1,$2 and addu $5,$3,$4 at count=0 -> next cycle out_cnt=1; ack 1 -> out_cnt=1 with the second instruction.
REQ-035 SHALL cover: push beq alone -> out_cnt=0; push nop next cycle -> out_cnt=2, slot 0=beq, slot 1=nop.
REQ-036 SHALL cover: DEPTH=8, push 2/cycle with no ack for 4 cycles -> count=8, in_ready=0; a fifth push is ignored; ack 2 -> in_ready=1.
REQ-037 SHALL cover: 6 entries buffered, push 2 + ack 2 + flush in the same cycle -> count=0 next cycle, out_cnt=0.
REQ-038 SHALL cover: syscall followed by addu -> out_cnt=1 with sy=1; after ack, addu is offered alone.
REQ-039 SHALL cover: with BYPASS_EN, count=0, push lw+sw with ack 1 -> lw offered same cycle; only sw is stored, count=1.
